// File: rtl/decode_issue_stage.sv
// Decode/issue stage: integer and vector register files with same-cycle writeback bypass,
// per-register pending scoreboard, and a single ID/EX output register with valid/ready handshake.
module decode_issue_stage #(
   parameter int REGI_BITS = 4,
   parameter int VECT_BITS = 2,
   parameter int REGI_SIZE = 16,
   parameter int ELEM_SIZE = 8,
   parameter int VECT_SIZE = 8,
   parameter int CTRL_W    = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [CTRL_W-1:0]                 in_ctrl,
   input  logic [2*REGI_BITS-1:0]            in_isrc,
   input  logic [2*VECT_BITS-1:0]            in_vsrc,
   input  logic [3:0]                        in_use,
   input  logic [REGI_BITS-1:0]              in_idst,
   input  logic [VECT_BITS-1:0]              in_vdst,
   input  logic [1:0]                        in_wr,
   input  logic [REGI_SIZE-1:0]              pc_i,
   input  logic                              int_we,
   input  logic [REGI_BITS-1:0]              int_wa,
   input  logic [REGI_SIZE-1:0]              int_wd,
   input  logic                              vec_we,
   input  logic [VECT_BITS-1:0]              vec_wa,
   input  logic [ELEM_SIZE*VECT_SIZE-1:0]    vec_wd,
   input  logic                              flush,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [CTRL_W-1:0]                 out_ctrl,
   output logic [2*REGI_SIZE-1:0]            out_ioper,
   output logic [2*ELEM_SIZE*VECT_SIZE-1:0]  out_voper,
   output logic [REGI_BITS-1:0]              out_idst,
   output logic [VECT_BITS-1:0]              out_vdst,
   output logic [1:0]                        out_wr
);

   localparam int VW = ELEM_SIZE * VECT_SIZE;
   localparam int NI = 2 ** REGI_BITS;
   localparam int NV = 2 ** VECT_BITS;
   localparam logic [REGI_BITS-1:0] PC_IDX = '1;

   // The top integer index is the PC and has no storage.
   logic [REGI_SIZE-1:0]       r_irf [NI-1];
   logic [VW-1:0]              r_vrf [NV];
   logic [NI-1:0]              r_ipend;
   logic [NV-1:0]              r_vpend;

   logic                       r_out_valid;
   logic [CTRL_W-1:0]          r_out_ctrl;
   logic [2*REGI_SIZE-1:0]     r_out_ioper;
   logic [2*VW-1:0]            r_out_voper;
   logic [REGI_BITS-1:0]       r_out_idst;
   logic [VECT_BITS-1:0]       r_out_vdst;
   logic [1:0]                 r_out_wr;

   logic [REGI_BITS-1:0]       w_isrc [2];
   logic [VECT_BITS-1:0]       w_vsrc [2];
   logic [REGI_SIZE-1:0]       w_iop  [2];
   logic [VW-1:0]              w_vop  [2];
   logic [NI-1:0]              w_iwb_hot;
   logic [NV-1:0]              w_vwb_hot;
   logic [NI-1:0]              w_ipend_eff;
   logic [NV-1:0]              w_vpend_eff;
   logic [NI-1:0]              w_ipend_nxt;
   logic [NV-1:0]              w_vpend_nxt;
   logic                       w_hazard;
   logic                       w_accept;

   assign w_isrc[0] = in_isrc[REGI_BITS-1:0];
   assign w_isrc[1] = in_isrc[2*REGI_BITS-1:REGI_BITS];
   assign w_vsrc[0] = in_vsrc[VECT_BITS-1:0];
   assign w_vsrc[1] = in_vsrc[2*VECT_BITS-1:VECT_BITS];

   always_comb begin
      for (int s = 0; s < 2; s++) begin
         w_iop[s] = '0;
         w_vop[s] = '0;
         if (in_use[s]) begin
            if (w_isrc[s] == PC_IDX)
               w_iop[s] = pc_i;
            else if (int_we && int_wa == w_isrc[s])
               w_iop[s] = int_wd;
            else
               w_iop[s] = r_irf[w_isrc[s]];
         end
         if (in_use[s+2]) begin
            if (vec_we && vec_wa == w_vsrc[s])
               w_vop[s] = vec_wd;
            else
               w_vop[s] = r_vrf[w_vsrc[s]];
         end
      end
   end

   // A register being written back this cycle is no longer a hazard.
   assign w_iwb_hot   = int_we ? ({{(NI-1){1'b0}}, 1'b1} << int_wa) : '0;
   assign w_vwb_hot   = vec_we ? ({{(NV-1){1'b0}}, 1'b1} << vec_wa) : '0;
   assign w_ipend_eff = r_ipend & ~w_iwb_hot;
   assign w_vpend_eff = r_vpend & ~w_vwb_hot;

   assign w_hazard = in_valid & ((in_use[0] & w_ipend_eff[w_isrc[0]]) |
                                 (in_use[1] & w_ipend_eff[w_isrc[1]]) |
                                 (in_use[2] & w_vpend_eff[w_vsrc[0]]) |
                                 (in_use[3] & w_vpend_eff[w_vsrc[1]]) |
                                 (in_wr[0]  & w_ipend_eff[in_idst])   |
                                 (in_wr[1]  & w_vpend_eff[in_vdst]));

   assign in_ready = ~w_hazard & ~flush & (~r_out_valid | out_ready);
   assign w_accept = in_valid & in_ready;

   always_comb begin
      w_ipend_nxt = w_ipend_eff;
      w_vpend_nxt = w_vpend_eff;
      if (flush && r_out_valid) begin
         if (r_out_wr[0]) w_ipend_nxt[r_out_idst] = 1'b0;
         if (r_out_wr[1]) w_vpend_nxt[r_out_vdst] = 1'b0;
      end
      if (w_accept) begin
         if (in_wr[0] && in_idst != PC_IDX) w_ipend_nxt[in_idst] = 1'b1;
         if (in_wr[1])                      w_vpend_nxt[in_vdst] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NI-1; i++) r_irf[i] <= '0;
         for (int i = 0; i < NV; i++)   r_vrf[i] <= '0;
         r_ipend     <= '0;
         r_vpend     <= '0;
         r_out_valid <= 1'b0;
         r_out_ctrl  <= '0;
         r_out_ioper <= '0;
         r_out_voper <= '0;
         r_out_idst  <= '0;
         r_out_vdst  <= '0;
         r_out_wr    <= '0;
      end else begin
         for (int i = 0; i < NI-1; i++)
            if (int_we && int_wa == REGI_BITS'(i)) r_irf[i] <= int_wd;
         for (int i = 0; i < NV; i++)
            if (vec_we && vec_wa == VECT_BITS'(i)) r_vrf[i] <= vec_wd;
         r_ipend <= w_ipend_nxt;
         r_vpend <= w_vpend_nxt;
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_ctrl  <= in_ctrl;
            r_out_ioper <= {w_iop[1], w_iop[0]};
            r_out_voper <= {w_vop[1], w_vop[0]};
            r_out_idst  <= in_idst;
            r_out_vdst  <= in_vdst;
            r_out_wr    <= in_wr;
         end else if (flush || out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_ctrl  = r_out_ctrl;
   assign out_ioper = r_out_ioper;
   assign out_voper = r_out_voper;
   assign out_idst  = r_out_idst;
   assign out_vdst  = r_out_vdst;
   assign out_wr    = r_out_wr;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Randomized scoreboard bench for decode_issue_stage: a register-level reference model predicts
// in_ready and each issued operand packet; a monitor pops and compares packets as they are consumed.
module tb_decode_issue_stage;
   localparam int RB = 4, VB = 2, RS = 16, CW = 32, VW = 64, NI = 16, NV = 4;

   logic              clk, rst;
   logic              in_valid, in_ready;
   logic [CW-1:0]     in_ctrl;
   logic [2*RB-1:0]   in_isrc;
   logic [2*VB-1:0]   in_vsrc;
   logic [3:0]        in_use;
   logic [RB-1:0]     in_idst;
   logic [VB-1:0]     in_vdst;
   logic [1:0]        in_wr;
   logic [RS-1:0]     pc_i;
   logic              int_we;
   logic [RB-1:0]     int_wa;
   logic [RS-1:0]     int_wd;
   logic              vec_we;
   logic [VB-1:0]     vec_wa;
   logic [VW-1:0]     vec_wd;
   logic              flush;
   logic              out_valid, out_ready;
   logic [CW-1:0]     out_ctrl;
   logic [2*RS-1:0]   out_ioper;
   logic [2*VW-1:0]   out_voper;
   logic [RB-1:0]     out_idst;
   logic [VB-1:0]     out_vdst;
   logic [1:0]        out_wr;

   decode_issue_stage #(.REGI_BITS(RB), .VECT_BITS(VB), .REGI_SIZE(RS), .ELEM_SIZE(8),
                        .VECT_SIZE(8), .CTRL_W(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
      .in_isrc(in_isrc), .in_vsrc(in_vsrc), .in_use(in_use), .in_idst(in_idst),
      .in_vdst(in_vdst), .in_wr(in_wr), .pc_i(pc_i), .int_we(int_we), .int_wa(int_wa),
      .int_wd(int_wd), .vec_we(vec_we), .vec_wa(vec_wa), .vec_wd(vec_wd), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
      .out_ioper(out_ioper), .out_voper(out_voper), .out_idst(out_idst),
      .out_vdst(out_vdst), .out_wr(out_wr));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [CW-1:0]   ctrl;
      logic [2*RS-1:0] iop;
      logic [2*VW-1:0] vop;
      logic [RB-1:0]   idst;
      logic [VB-1:0]   vdst;
      logic [1:0]      wr;
   } pkt_t;

   pkt_t         sb[$];
   logic [RS-1:0] m_irf [NI];
   logic [VW-1:0] m_vrf [NV];
   bit           m_ip [NI];
   bit           m_vp [NV];
   bit           m_valid;
   logic         last_rdy;
   int           checks = 0;
   int           errors = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < NI; i++) begin m_irf[i] = '0; m_ip[i] = 0; end
      for (int i = 0; i < NV; i++) begin m_vrf[i] = '0; m_vp[i] = 0; end
      m_valid = 0;
      sb.delete();
   endtask

   function automatic logic [RS-1:0] irf_read(input logic [RB-1:0] idx, input logic used);
      if (!used) return '0;
      if (idx == RB'(NI-1)) return pc_i;
      if (int_we && int_wa == idx) return int_wd;
      return m_irf[idx];
   endfunction

   function automatic logic [VW-1:0] vrf_read(input logic [VB-1:0] idx, input logic used);
      if (!used) return '0;
      if (vec_we && vec_wa == idx) return vec_wd;
      return m_vrf[idx];
   endfunction

   function automatic bit ibusy(input logic [RB-1:0] idx);
      return m_ip[idx] && !(int_we && int_wa == idx);
   endfunction

   function automatic bit vbusy(input logic [VB-1:0] idx);
      return m_vp[idx] && !(vec_we && vec_wa == idx);
   endfunction

   task automatic idle();
      in_valid = 0; in_use = '0; in_wr = '0; int_we = 0; vec_we = 0; flush = 0; out_ready = 1;
   endtask

   // Evaluate the current cycle's inputs against the model, then advance to just past the edge.
   task automatic eval();
      bit haz, rdy, acc;
      pkt_t p;
      #1;
      haz = in_valid && ((in_use[0] && ibusy(in_isrc[RB-1:0])) ||
                         (in_use[1] && ibusy(in_isrc[2*RB-1:RB])) ||
                         (in_use[2] && vbusy(in_vsrc[VB-1:0])) ||
                         (in_use[3] && vbusy(in_vsrc[2*VB-1:VB])) ||
                         (in_wr[0] && ibusy(in_idst)) || (in_wr[1] && vbusy(in_vdst)));
      rdy = !haz && !flush && (!m_valid || out_ready);
      last_rdy = in_ready;
      check("in_ready", in_ready, rdy);
      check("out_valid", out_valid, m_valid);
      acc = in_valid && rdy;
      if (acc) begin
         p.ctrl = in_ctrl;
         p.iop  = {irf_read(in_isrc[2*RB-1:RB], in_use[1]), irf_read(in_isrc[RB-1:0], in_use[0])};
         p.vop  = {vrf_read(in_vsrc[2*VB-1:VB], in_use[3]), vrf_read(in_vsrc[VB-1:0], in_use[2])};
         p.idst = in_idst; p.vdst = in_vdst; p.wr = in_wr;
      end
      if (flush && m_valid && sb.size() > 0) begin
         if (sb[0].wr[0]) m_ip[sb[0].idst] = 0;
         if (sb[0].wr[1]) m_vp[sb[0].vdst] = 0;
         void'(sb.pop_front());
      end
      if (int_we) begin
         if (int_wa != RB'(NI-1)) m_irf[int_wa] = int_wd;
         m_ip[int_wa] = 0;
      end
      if (vec_we) begin m_vrf[vec_wa] = vec_wd; m_vp[vec_wa] = 0; end
      if (acc) begin
         if (in_wr[0] && in_idst != RB'(NI-1)) m_ip[in_idst] = 1;
         if (in_wr[1]) m_vp[in_vdst] = 1;
         sb.push_back(p);
      end
      m_valid = acc ? 1'b1 : ((flush || out_ready) ? 1'b0 : m_valid);
      @(posedge clk); #1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rst && out_valid && out_ready && !flush) begin
            if (sb.size() == 0) begin
               check("unexpected_output", 1'b1, 1'b0);
            end else begin
               pkt_t e;
               e = sb.pop_front();
               check("ioper", out_ioper, e.iop);
               check("voper", out_voper, e.vop);
               check("ctrl_dst_wr", {out_ctrl, out_idst, out_vdst, out_wr},
                     {e.ctrl, e.idst, e.vdst, e.wr});
            end
         end
      end
   end

   initial begin
      rst = 0; in_ctrl = '0; in_isrc = '0; in_vsrc = '0; in_idst = '0; in_vdst = '0;
      pc_i = '0; int_wa = '0; int_wd = '0; vec_wa = '0; vec_wd = '0;
      idle();
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_outs", {out_ctrl, out_ioper, out_idst, out_vdst, out_wr}, '0);
      check("rst_in_ready", in_ready, 1'b1);
      rst = 1;

      // r3 write then read r3 and the PC index
      idle(); int_we = 1; int_wa = 3; int_wd = 16'h1234; eval();
      idle(); in_valid = 1; in_isrc = {4'd15, 4'd3}; in_use = 4'b0011; pc_i = 16'h0040;
      in_ctrl = 32'hA0A0_0001; eval();
      check("pc_r3_oper", out_ioper, 32'h0040_1234);

      // same-cycle writeback bypass
      idle(); int_we = 1; int_wa = 5; int_wd = 16'hBEEF; in_valid = 1; in_isrc = {4'd0, 4'd5};
      in_use = 4'b0001; in_ctrl = 32'hA0A0_0002; eval();
      check("bypass_r5", out_ioper[RS-1:0], 16'hBEEF);

      // RAW stall on r2 until its writeback
      idle(); in_valid = 1; in_wr = 2'b01; in_idst = 2; in_ctrl = 32'hA0A0_0003; eval();
      idle(); in_valid = 1; in_use = 4'b0001; in_isrc = {4'd0, 4'd2}; in_ctrl = 32'hA0A0_0004;
      for (int i = 0; i < 3; i++) begin
         eval();
         check("raw_stall", last_rdy, 1'b0);
      end
      int_we = 1; int_wa = 2; int_wd = 16'hCAFE; eval();
      check("raw_release", last_rdy, 1'b1);
      check("raw_bypass", out_ioper[RS-1:0], 16'hCAFE);

      // backpressure: output holds for two cycles
      idle(); in_valid = 1; in_ctrl = 32'h5555_0001; eval();
      idle(); in_valid = 1; in_ctrl = 32'h5555_0002; out_ready = 0;
      for (int i = 0; i < 2; i++) begin
         eval();
         check("bp_stall", last_rdy, 1'b0);
         check("bp_stable", out_ctrl, 32'h5555_0001);
      end
      out_ready = 1; eval();
      check("bp_drain_accept", last_rdy, 1'b1);
      check("bp_next", out_ctrl, 32'h5555_0002);

      // flush of a held vector-writing instruction releases v1
      idle(); in_valid = 1; in_wr = 2'b10; in_vdst = 1; in_ctrl = 32'h6666_0001; eval();
      idle(); out_ready = 0; flush = 1; eval();
      check("flush_valid", out_valid, 1'b0);
      idle(); in_valid = 1; in_use = 4'b0100; in_vsrc = {2'd0, 2'd1}; in_ctrl = 32'h6666_0002;
      eval();
      check("flush_no_stall", last_rdy, 1'b1);

      // reset while r7 pending
      idle(); in_valid = 1; in_wr = 2'b01; in_idst = 7; in_ctrl = 32'h7777_0001; eval();
      idle(); out_ready = 0; #2; rst = 0; #1;
      check("rst_mid_valid", out_valid, 1'b0);
      m_reset();
      @(posedge clk); #1; rst = 1;
      idle(); in_valid = 1; in_use = 4'b0001; in_isrc = {4'd0, 4'd7}; in_ctrl = 32'h7777_0002;
      eval();
      check("rst_r7_no_stall", last_rdy, 1'b1);
      check("rst_r7_zero", out_ioper[RS-1:0], 16'h0000);

      for (int n = 0; n < 1500; n++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_ctrl   = $urandom;
         in_isrc   = RB'($urandom) | (2*RB)'($urandom) ;
         in_vsrc   = (2*VB)'($urandom);
         in_use    = 4'($urandom);
         in_idst   = RB'($urandom);
         in_vdst   = VB'($urandom);
         in_wr     = 2'($urandom);
         pc_i      = RS'($urandom);
         int_we    = ($urandom_range(0, 9) < 4);
         int_wa    = RB'($urandom);
         int_wd    = RS'($urandom);
         vec_we    = ($urandom_range(0, 9) < 3);
         vec_wa    = VB'($urandom);
         vec_wd    = {$urandom, $urandom};
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 19) == 0);
         eval();
      end
      idle();
      repeat (3) eval();
      check("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/decode_issue_stage.md
DECODE_ISSUE_STAGE -- requirements
Module: decode_issue_stage

Interface
REQ-001 SHALL have parameter REGI_BITS, default 4, integer register index width.
REQ-002 SHALL have parameter VECT_BITS, default 2, vector register index width.
REQ-003 SHALL have parameter REGI_SIZE, default 16, integer register data width.
REQ-004 SHALL have parameter ELEM_SIZE, default 8, bits per vector lane.
REQ-005 SHALL have parameter VECT_SIZE, default 8, lanes per vector register; VW = ELEM_SIZE*VECT_SIZE.
REQ-006 SHALL have parameter CTRL_W, default 32, opaque decoded-control bundle width, passed through untouched.
REQ-007 SHALL have port clk  in  1  sole clock, rising edge.
REQ-008 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have port in_valid  in  1  decoded instruction present.
REQ-010 SHALL have port in_ready  out  1  instruction accepted this cycle when high with in_valid.
REQ-011 SHALL have port in_ctrl  in  CTRL_W  control bundle from decoder.
REQ-012 SHALL have port in_isrc  in  2*REGI_BITS  int sources; [REGI_BITS-1:0]=src1, upper=src2.
REQ-013 SHALL have port in_vsrc  in  2*VECT_BITS  vec sources; low=src1, upper=src2.
REQ-014 SHALL have port in_use  in  4  source-used bits {vsrc2,vsrc1,isrc2,isrc1}.
REQ-015 SHALL have port in_idst  in  REGI_BITS  int destination.
REQ-016 SHALL have port in_vdst  in  VECT_BITS  vec destination.
REQ-017 SHALL have port in_wr  in  2  result-write bits {vec,int}.
REQ-018 SHALL have port pc_i  in  REGI_SIZE  next PC, returned for reads of int index 2**REGI_BITS-1.
REQ-019 SHALL have port int_we  in  1  int writeback enable.
REQ-020 SHALL have port int_wa  in  REGI_BITS  int writeback index.
REQ-021 SHALL have port int_wd  in  REGI_SIZE  int writeback data.
REQ-022 SHALL have port vec_we  in  1  vec writeback enable.
REQ-023 SHALL have port vec_wa  in  VECT_BITS  vec writeback index.
REQ-024 SHALL have port vec_wd  in  VW  vec writeback data.
REQ-025 SHALL have port flush  in  1  kill held output instruction.
REQ-026 SHALL have port out_valid  out  1  ID/EX register holds an instruction.
REQ-027 SHALL have port out_ready  in  1  execute stage consumes when high with out_valid.
REQ-028 SHALL have port out_ctrl  out  CTRL_W  registered in_ctrl.
REQ-029 SHALL have port out_ioper  out  2*REGI_SIZE  int operands {op2,op1}; unused source reads 0.
REQ-030 SHALL have port out_voper  out  2*VW  vec operands {op2,op1}; unused source reads 0.
REQ-031 SHALL have ports out_idst (REGI_BITS), out_vdst (VECT_BITS), out_wr (2), all out, registered copies of in_idst, in_vdst, in_wr.

Function
REQ-032 SHALL hold int RF 2**REGI_BITS x REGI_SIZE (top index not stored; reads pc_i; writes to it ignored) and vec RF 2**VECT_BITS x VW, both written at the rising edge.
REQ-033 SHALL bypass reads: source index equal to an active same-cycle writeback index returns the writeback data.
REQ-034 SHALL keep one pending bit per int and per vec register; hazard = in_valid and (a used source is pending, or the in_wr destination is pending), excluding any index being written back this cycle; PC index is never pending.
REQ-035 SHALL drive in_ready = !hazard & !flush & (!out_valid | out_ready), combinationally.
REQ-036 SHALL, on accept, load all out_* fields with operands at the next edge, set out_valid and set the pending bit of each in_wr destination; latency is 1 cycle.
REQ-037 SHALL clear out_valid on out_ready without accept; out_* SHALL stay stable while out_valid & !out_ready.
REQ-038 SHALL clear the pending bit at a writeback edge; same-edge set by accept wins over the clear.
REQ-039 SHALL, on flush, clear out_valid and clear the pending bits set by the held instruction; flush overrides out_ready.

Reset
REQ-040 SHALL, with rst low, asynchronously zero out_valid, all out_*, all pending bits and both RFs; in_ready follows REQ-035 from zeroed state.

Verification
REQ-041 SHALL check: int_we r3=0x1234, then issue isrc1=3, isrc2=15, pc_i=0x0040 -> out_ioper={0x0040,0x1234} one edge after accept.
REQ-042 SHALL check: int_we r5=0xBEEF in the accept cycle of isrc1=5 -> op1=0xBEEF.
REQ-043 SHALL check: issue in_wr int idst=2, then isrc1=2 -> in_ready=0 until int_we wa=2 cycle, accepted that cycle with bypassed data.
REQ-044 SHALL check: out_ready=0 for 2 cycles -> out_* stable, in_ready=0; out_ready=1 -> drains, next accept.
REQ-045 SHALL check: held instruction vdst=1 flushed -> out_valid=0 next edge; next instruction reading v1 accepted with no stall.
REQ-046 SHALL check: rst low while r7 pending -> out_valid=0; after release, read of r7 returns 0 with no stall.
